// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: ISA constants, fetch FSM state and PC-select encoding shared by the fetch stage
package fetch_stage_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [15:0] NOP_WORD = {OP_NOP, 12'h000};
  localparam logic [15:0] DEF_IMM_OP_MASK = 16'h0000;
  localparam logic [15:0] DEF_INT_VECTOR = 16'h0002;
  typedef enum logic {RUN, INJECT} fetch_state_t;
  typedef enum logic [2:0] {PC_SEQ, PC_BRANCH, PC_RET, PC_VECTOR, PC_HOLD} pc_sel_t;
  function automatic logic takes_imm(input logic [15:0] mask, input logic [15:0] word);
    return mask[word[15:12]];
  endfunction
endpackage

// File: rtl/fetch_stage_pc_unit.sv
// fetch_stage_pc_unit: program counter register with next-PC select (seq, branch, ret, vector, hold)
module fetch_stage_pc_unit
  import fetch_stage_pkg::*;
#(
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] INT_VECTOR = PC_W'(DEF_INT_VECTOR)
) (
  input  logic            clk,
  input  logic            reset,
  input  pc_sel_t         sel,
  input  logic [PC_W-1:0] branch_target,
  input  logic [PC_W-1:0] ret_pc,
  output logic [PC_W-1:0] pc
);
  logic [PC_W-1:0] pc_nxt;
  always_comb
    pc_nxt = sel == PC_BRANCH ? branch_target :
             sel == PC_RET    ? ret_pc :
             sel == PC_VECTOR ? INT_VECTOR :
             sel == PC_HOLD   ? pc : pc + PC_W'(1);
  always_ff @(posedge clk) pc <= reset ? RESET_PC : pc_nxt;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF/ID producer with immediate-word tracking and boundary-only interrupt injection
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] INT_VECTOR = PC_W'(DEF_INT_VECTOR),
  parameter logic [15:0] IMM_OP_MASK = DEF_IMM_OP_MASK
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            ret_load,
  input  logic [PC_W-1:0] ret_pc,
  input  logic            interrupt,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [15:0]     instr_out,
  output logic [PC_W-1:0] pc_next_out,
  output logic            imm_word_out,
  output logic            int_out,
  output logic            int_ack
);
  fetch_state_t state;
  pc_sel_t pc_sel;
  logic [PC_W-1:0] pc;
  logic imm_expect, int_pend, redirect, inject, hold, take;
  always_comb begin
    redirect = branch_taken | ret_load;
    inject = (state == RUN) & int_pend & ~imm_expect & ~stall & ~redirect;
    hold = ~redirect & stall & ~flush;
    take = ~redirect & ~stall & ~inject & ~flush;
    pc_sel = branch_taken ? PC_BRANCH : ret_load ? PC_RET : stall ? PC_HOLD :
             inject ? PC_VECTOR : PC_SEQ;
  end
  fetch_stage_pc_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC), .INT_VECTOR(INT_VECTOR)) u_pc (
    .clk(clk),
    .reset(reset),
    .sel(pc_sel),
    .branch_target(branch_target),
    .ret_pc(ret_pc),
    .pc(pc)
  );
  assign imem_addr = pc;
  // An injected slot carries the unfetched pc as its resume address
  always_ff @(posedge clk)
    if (reset) begin
      state <= RUN;
      instr_out <= NOP_WORD;
      pc_next_out <= '0;
      imm_word_out <= 1'b0;
      int_out <= 1'b0;
      int_ack <= 1'b0;
      int_pend <= 1'b0;
      imm_expect <= 1'b0;
    end else begin
      state <= inject ? INJECT : RUN;
      int_ack <= inject;
      int_pend <= ~inject & (int_pend | interrupt);
      if (!hold) begin
        instr_out <= take ? imem_data : NOP_WORD;
        pc_next_out <= take ? pc + PC_W'(1) : inject ? pc : '0;
        imm_word_out <= take & imm_expect;
        int_out <= inject;
        imm_expect <= take & ~imm_expect & takes_imm(IMM_OP_MASK, imem_data);
      end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a cycle model of the fetch stage and literal spot checks
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset, stall, flush, branch_taken, ret_load, interrupt;
  logic [15:0] branch_target, ret_pc, imem_addr, imem_data, instr_out, pc_next_out;
  logic imm_word_out, int_out, int_ack;
  logic [15:0] mem [0:65535];
  bit [15:0] imm_mask = 16'h0004;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [15:0] m_pc, m_instr, m_pcn, m_word;
  logic m_imm, m_int, m_ack, m_exp, m_pend, m_inj, m_go;

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];

  fetch_stage #(.IMM_OP_MASK(16'h0004)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .flush(flush),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .ret_load(ret_load),
    .ret_pc(ret_pc),
    .interrupt(interrupt),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .instr_out(instr_out),
    .pc_next_out(pc_next_out),
    .imm_word_out(imm_word_out),
    .int_out(int_out),
    .int_ack(int_ack)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic nop_slot();
    m_instr = 16'h0000;
    m_pcn = 16'h0000;
    m_imm = 1'b0;
    m_int = 1'b0;
  endtask

  // Reference behaviour, applied in priority order once per rising edge
  always @(posedge clk) begin
    if (reset) begin
      m_pc = 16'h0000;
      nop_slot();
      m_ack = 1'b0;
      m_exp = 1'b0;
      m_pend = 1'b0;
      m_inj = 1'b0;
    end else begin
      m_word = mem[m_pc];
      m_go = !m_inj && m_pend && !m_exp && !stall && !branch_taken && !ret_load;
      m_ack = m_go;
      m_inj = m_go;
      if (branch_taken || ret_load) begin
        m_pc = branch_taken ? branch_target : ret_pc;
        nop_slot();
        m_exp = 1'b0;
      end else if (stall) begin
        if (flush) begin
          nop_slot();
          m_exp = 1'b0;
        end
      end else if (m_go) begin
        nop_slot();
        m_int = 1'b1;
        m_pcn = m_pc;
        m_pc = 16'h0002;
      end else if (flush) begin
        nop_slot();
        m_exp = 1'b0;
        m_pc = m_pc + 16'd1;
      end else begin
        m_instr = m_word;
        m_int = 1'b0;
        m_pcn = m_pc + 16'd1;
        m_imm = m_exp;
        m_exp = m_exp ? 1'b0 : imm_mask[m_word[15:12]];
        m_pc = m_pc + 16'd1;
      end
      m_pend = m_go ? 1'b0 : (m_pend | interrupt);
    end
  end

  always @(negedge clk)
    if (chk_en) begin
      chk("model_instr", instr_out, m_instr);
      chk("model_pcnext", pc_next_out, m_pcn);
      chk("model_imm", {15'd0, imm_word_out}, {15'd0, m_imm});
      chk("model_int", {15'd0, int_out}, {15'd0, m_int});
      chk("model_ack", {15'd0, int_ack}, {15'd0, m_ack});
      chk("model_addr", imem_addr, m_pc);
    end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic branch_to(input logic [15:0] t);
    branch_taken = 1'b1;
    branch_target = t;
    cyc();
    branch_taken = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
    mem[16'h10] = 16'h2ABC; mem[16'h11] = 16'h2005; mem[16'h12] = 16'h1234;
    mem[16'h20] = 16'h2111; mem[16'h21] = 16'h0777; mem[16'h22] = 16'h3333;
    mem[16'h30] = 16'h1A30; mem[16'h31] = 16'h1A31; mem[16'h40] = 16'h1B40;
    mem[16'hFFFF] = 16'h1FFF;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; ret_load = 1'b0;
    interrupt = 1'b0; branch_target = 16'h0000; ret_pc = 16'h0000;
    cyc(); cyc();
    chk("rst_instr", instr_out, 16'h0000);
    chk("rst_pcnext", pc_next_out, 16'h0000);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_int", {int_out, int_ack, imm_word_out}, 16'h0000);
    chk_en = 1'b1;
    reset = 1'b0;
    cyc(); chk("t1_i1", instr_out, 16'h1111); chk("t1_n1", pc_next_out, 16'h0001);
    cyc(); chk("t1_i2", instr_out, 16'h2222); chk("t1_n2", pc_next_out, 16'h0002);
    cyc(); chk("t1_i3", instr_out, 16'h3333); chk("t1_n3", pc_next_out, 16'h0003);
    chk("t1_imm3", {15'd0, imm_word_out}, 16'h0001);
    branch_to(16'h0010);
    chk("t2_br_nop", instr_out, 16'h0000); chk("t2_br_addr", imem_addr, 16'h0010);
    cyc(); chk("t2_op", instr_out, 16'h2ABC); chk("t2_op_imm", {15'd0, imm_word_out}, 16'h0000);
    cyc(); chk("t2_imm", instr_out, 16'h2005); chk("t2_imm_flag", {15'd0, imm_word_out}, 16'h0001);
    cyc(); chk("t2_after", instr_out, 16'h1234); chk("t2_after_imm", {15'd0, imm_word_out}, 16'h0000);
    branch_to(16'h0020);
    cyc();
    interrupt = 1'b1;
    cyc(); chk("t3_immword", {15'd0, imm_word_out}, 16'h0001); chk("t3_noinj", {15'd0, int_out}, 16'h0000);
    interrupt = 1'b0;
    cyc(); chk("t3_int", {15'd0, int_out}, 16'h0001); chk("t3_ack", {15'd0, int_ack}, 16'h0001);
    chk("t3_resume", pc_next_out, 16'h0022); chk("t3_vec", imem_addr, 16'h0002);
    cyc(); chk("t3_vecfetch", instr_out, 16'h3333); chk("t3_ackdrop", {15'd0, int_ack}, 16'h0000);
    interrupt = 1'b1;
    cyc();
    interrupt = 1'b0;
    branch_to(16'h0050);
    chk("rw_noinj", {15'd0, int_out}, 16'h0000); chk("rw_addr", imem_addr, 16'h0050);
    cyc(); chk("rw_retry", {15'd0, int_out}, 16'h0001); chk("rw_resume", pc_next_out, 16'h0050);
    cyc();
    branch_to(16'h0030);
    cyc(); chk("t4_pre", instr_out, 16'h1A30);
    stall = 1'b1;
    cyc(); chk("t4_hold1", instr_out, 16'h1A30); chk("t4_hold1_pc", imem_addr, 16'h0031);
    cyc(); chk("t4_hold2", instr_out, 16'h1A30); chk("t4_hold2_pc", imem_addr, 16'h0031);
    branch_to(16'h0040);
    chk("t4_br_nop", instr_out, 16'h0000); chk("t4_br_pc", imem_addr, 16'h0040);
    stall = 1'b0;
    cyc(); chk("t4_target", instr_out, 16'h1B40); chk("t4_target_n", pc_next_out, 16'h0041);
    branch_to(16'hFFFF);
    cyc(); chk("t5_last", instr_out, 16'h1FFF); chk("t5_wrap", pc_next_out, 16'h0000);
    chk("t5_wrap_pc", imem_addr, 16'h0000);
    interrupt = 1'b1;
    cyc();
    interrupt = 1'b0;
    cyc(); chk("t5_inj", {15'd0, int_out}, 16'h0001);
    reset = 1'b1;
    cyc(); chk("t5_rst_instr", instr_out, 16'h0000); chk("t5_rst_int", {int_out, int_ack}, 16'h0000);
    chk("t5_rst_pc", imem_addr, 16'h0000); chk("t5_rst_n", pc_next_out, 16'h0000);
    reset = 1'b0;
    cyc(); chk("t5_restart", instr_out, 16'h1111);
    flush = 1'b1;
    cyc(); chk("fl_nop", instr_out, 16'h0000); chk("fl_adv", imem_addr, 16'h0002);
    flush = 1'b0;
    ret_load = 1'b1; ret_pc = 16'h0010;
    cyc(); chk("ret_addr", imem_addr, 16'h0010);
    ret_load = 1'b0;
    cyc(); chk("ret_fetch", instr_out, 16'h2ABC);
    cyc(); cyc();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
